// File: rtl/udxs_sqrt_pkg.sv
// Shared types and derived-size helpers for the integer square-root engine.
package udxs_sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of root bits (and iterations) for a given query width.
  function automatic int unsigned half_w(input int unsigned width);
    return width / 2;
  endfunction

  // Clock cycles per job; guards against a zero step count during elaboration.
  function automatic int unsigned cycles(input int unsigned width, input int unsigned steps);
    return (steps == 0) ? 1 : (width / 2) / steps;
  endfunction

endpackage

// File: rtl/udxs_sqrt_step.sv
// One restoring digit-by-digit iteration: consumes the top two query bits.
module udxs_sqrt_step
  import udxs_sqrt_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]         q,
  input  logic [WIDTH/2-1:0]       r,
  input  logic [WIDTH/2+1:0]       e,
  output logic [WIDTH-1:0]         q_nxt_c,
  output logic [WIDTH/2-1:0]       r_nxt_c,
  output logic [WIDTH/2+1:0]       e_nxt_c
);

  localparam int unsigned H  = half_w(WIDTH);
  localparam int unsigned EW = H + 2;
  localparam int unsigned XW = EW + 2;

  logic [XW-1:0] e_sh;
  logic [XW-1:0] t;

  // The remainder never grows past H+1 bits, so the widened compare equals the EW-bit one.
  always_comb begin
    e_sh    = {e, q[WIDTH-1:WIDTH-2]};
    t       = {2'b00, r, 2'b01};
    q_nxt_c = {q[WIDTH-3:0], 2'b00};
    r_nxt_c = {r[H-2:0], 1'b0};
    e_nxt_c = EW'(e_sh);
    if (e_sh >= t) begin
      e_nxt_c = EW'(e_sh - t);
      r_nxt_c = {r[H-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/udxs_sqrt_engine.sv
// Integer square-root engine: floor(sqrt(query)) and remainder, valid/ready framed,
// STEPS_PER_CYCLE restoring iterations per clock.
module udxs_sqrt_engine
  import udxs_sqrt_pkg::*;
#(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned STEPS_PER_CYCLE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   query,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   rem,
  output logic               busy
);

  localparam int unsigned H     = half_w(WIDTH);
  localparam int unsigned EW    = H + 2;
  localparam int unsigned C     = cycles(WIDTH, STEPS_PER_CYCLE);
  localparam int unsigned CNT_W = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned S     = STEPS_PER_CYCLE;

  if ((WIDTH % 2 != 0) || (WIDTH < 4) || (S == 0) || ((WIDTH / 2) % S != 0)) begin : g_param_check
    $error("udxs_sqrt_engine: WIDTH must be even and >= 4, STEPS_PER_CYCLE must divide WIDTH/2");
  end

  state_t             state;
  state_t             state_nxt;
  logic               accept_c;
  logic               run_c;
  logic               last_c;
  logic [WIDTH-1:0]   q;
  logic [H-1:0]       r;
  logic [EW-1:0]      e;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   q_s [S+1];
  logic [H-1:0]       r_s [S+1];
  logic [EW-1:0]      e_s [S+1];

  assign q_s[0] = q;
  assign r_s[0] = r;
  assign e_s[0] = e;

  // Unrolled iteration chain evaluated once per RUN cycle.
  for (genvar i = 0; i < S; i++) begin : g_step
    udxs_sqrt_step #(.WIDTH(WIDTH)) u_step (
      .q       (q_s[i]),
      .r       (r_s[i]),
      .e       (e_s[i]),
      .q_nxt_c (q_s[i+1]),
      .r_nxt_c (r_s[i+1]),
      .e_nxt_c (e_s[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Flush overrides every transition, including an accept in IDLE.
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    run_c     = 1'b0;
    last_c    = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            accept_c  = 1'b1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          run_c = 1'b1;
          if (cnt == '0) begin
            last_c    = 1'b1;
            state_nxt = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      r    <= '0;
      e    <= '0;
      cnt  <= '0;
      root <= '0;
      rem  <= '0;
    end else if (accept_c) begin
      q   <= query;
      r   <= '0;
      e   <= '0;
      cnt <= CNT_W'(C - 1);
    end else if (run_c) begin
      q   <= q_s[S];
      r   <= r_s[S];
      e   <= e_s[S];
      cnt <= cnt - CNT_W'(1);
      if (last_c) begin
        root <= r_s[S];
        rem  <= e_s[S][H:0];
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

endmodule

// File: tb/tb_udxs_sqrt_engine.sv
// Scoreboard bench for udxs_sqrt_engine at 16/2 and 8/4 configurations.
module tb_udxs_sqrt_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] query = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  root;
  logic [8:0]  rem;
  logic        busy;

  logic        flush8 = 1'b0;
  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  query8 = '0;
  logic        out_valid8;
  logic        out_ready8 = 1'b0;
  logic [3:0]  root8;
  logic [4:0]  rem8;
  logic        busy8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  root;
    logic [8:0]  rem;
  } job_t;

  job_t sb[$];

  always #5 clk = ~clk;

  udxs_sqrt_engine #(.WIDTH(16), .STEPS_PER_CYCLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .query(query), .out_valid(out_valid), .out_ready(out_ready), .root(root), .rem(rem),
    .busy(busy)
  );

  udxs_sqrt_engine #(.WIDTH(8), .STEPS_PER_CYCLE(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
    .query(query8), .out_valid(out_valid8), .out_ready(out_ready8), .root(root8), .rem(rem8),
    .busy(busy8)
  );

  function automatic void model(input int unsigned v, output int unsigned rt, output int unsigned rm);
    rt = 0;
    while ((rt + 1) * (rt + 1) <= v) rt++;
    rm = v - rt * rt;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] qv);
    int n = 0;
    int unsigned rt, rm;
    while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    query    = qv;
    tick();
    in_valid = 1'b0;
    query    = ~qv;
    model(32'(qv), rt, rm);
    sb.push_back('{qv, 8'(rt), 9'(rm)});
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL accept in_ready=%0b busy=%0b required 0 1", in_ready, busy);
    end
  endtask

  task automatic collect(input string name);
    int   lat = 0;
    job_t exp = '{16'd0, 8'd0, 9'd0};
    while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL %s_latency cycles=%0d required 4", name, lat);
    end
    if (sb.size() > 0) exp = sb.pop_front();
    checks++;
    if (root !== exp.root || rem !== exp.rem) begin
      errors++;
      $display("FAIL %s_result q=%0d root=%0d rem=%0d required root=%0d rem=%0d",
               name, exp.q, root, rem, exp.root, exp.rem);
    end
    checks++;
    if ((int'(root) * int'(root) + int'(rem) != int'(exp.q)) || (int'(rem) > 2 * int'(root))) begin
      errors++;
      $display("FAIL %s_invariant q=%0d root=%0d rem=%0d", name, exp.q, root, rem);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release out_valid=%0b in_ready=%0b required 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (root !== 8'd0 || rem !== 9'd0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset root=%0d rem=%0d out_valid=%0b busy=%0b in_ready=%0b required 0 0 0 0 1",
               root, rem, out_valid, busy, in_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_values();
    send(16'd144);    collect("q144");
    send(16'd143);    collect("q143");
    send(16'd0);      collect("q0");
    send(16'd65535);  collect("qmax");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) begin
      send(16'($urandom));
      collect("rand");
    end
  endtask

  task automatic test_hold();
    int   n = 0;
    job_t exp;
    logic [7:0] r0;
    logic [8:0] m0;
    send(16'd5000);
    while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    r0 = root;
    m0 = rem;
    exp = sb.pop_front();
    checks++;
    if (r0 !== exp.root || m0 !== exp.rem) begin
      errors++;
      $display("FAIL hold_result root=%0d rem=%0d required root=%0d rem=%0d", r0, m0, exp.root, exp.rem);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      query    = 16'($urandom);
      tick();
      checks++;
      if (out_valid !== 1'b1 || root !== exp.root || rem !== exp.rem || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable cyc=%0d out_valid=%0b root=%0d rem=%0d in_ready=%0b", i, out_valid, root, rem, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_no_queue cyc=%0d busy=%0b out_valid=%0b required 0 0", i, busy, out_valid);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    send(16'd30000);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (root !== 8'd0 || rem !== 9'd0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid root=%0d rem=%0d out_valid=%0b busy=%0b in_ready=%0b required 0 0 0 0 1",
               root, rem, out_valid, busy, in_ready);
    end
    void'(sb.pop_back());
    tick();
    rst_n = 1'b1;
    tick();
    send(16'd10000);
    collect("q10000");
  endtask

  task automatic test_flush();
    int n = 0;
    send(16'd1234);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    void'(sb.pop_back());
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || root !== 8'd100 || rem !== 9'd0) begin
      errors++;
      $display("FAIL flush_run in_ready=%0b busy=%0b out_valid=%0b root=%0d rem=%0d required 1 0 0 100 0",
               in_ready, busy, out_valid, root, rem);
    end
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid === 1'b1) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL flush_no_result valid_cycles=%0d required 0", n);
    end
    send(16'd50);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    void'(sb.pop_back());
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || root !== 8'd7 || rem !== 9'd1) begin
      errors++;
      $display("FAIL flush_done out_valid=%0b in_ready=%0b root=%0d rem=%0d required 0 1 7 1",
               out_valid, in_ready, root, rem);
    end
    in_valid = 1'b1;
    flush    = 1'b1;
    query    = 16'd99;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle in_ready=%0b busy=%0b required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_width8();
    logic [7:0] vals [4];
    int unsigned rt, rm;
    int lat;
    vals[0] = 8'd200; vals[1] = 8'd255; vals[2] = 8'd0; vals[3] = 8'd37;
    for (int i = 0; i < 4; i++) begin
      lat = 0;
      while (in_ready8 !== 1'b1 && lat < 20) begin tick(); lat++; end
      in_valid8 = 1'b1;
      query8    = vals[i];
      tick();
      in_valid8 = 1'b0;
      query8    = ~vals[i];
      model(32'(vals[i]), rt, rm);
      lat = 0;
      while (out_valid8 !== 1'b1 && lat < 20) begin tick(); lat++; end
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL w8_latency q=%0d cycles=%0d required 1", vals[i], lat);
      end
      checks++;
      if (root8 !== 4'(rt) || rem8 !== 5'(rm)) begin
        errors++;
        $display("FAIL w8_result q=%0d root=%0d rem=%0d required root=%0d rem=%0d", vals[i], root8, rem8, rt, rm);
      end
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_values();
    test_back_to_back();
    test_hold();
    test_reset_mid_run();
    test_flush();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
